// File: rtl/rapcla_accuracy_ctrl_pkg.sv
// Shared definitions for the RAPCLA accuracy controller: mode and state
// encodings, group/level width derivation and the level -> ApproxRCON helper.
package rapcla_accuracy_ctrl_pkg;

  localparam int MAX_GROUPS = 32;

  typedef enum logic [1:0] {
    QM_EXACT = 2'd0,
    QM_FIXED = 2'd1,
    QM_ADAPT = 2'd2,
    QM_RSVD  = 2'd3
  } qmode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int groups_of(input int size, input int gsize);
    return size / gsize;
  endfunction

  // LEVEL must represent 0..NGROUPS inclusive.
  function automatic int level_width(input int ngroups);
    return (ngroups < 1) ? 1 : $clog2(ngroups + 1);
  endfunction

  // Level L approximates the L least-significant groups.
  function automatic logic [MAX_GROUPS-1:0] level_mask(input int unsigned level);
    if (level >= MAX_GROUPS) return '1;
    return (MAX_GROUPS'(1) << level) - MAX_GROUPS'(1);
  endfunction

endpackage

// File: rtl/rapcla_accuracy_ctrl_adder.sv
// RAPCLA_p_v reconfigurable approximate carry look-ahead adder.
// Operands are split into GROUPSIZE-bit groups. An exact group takes the true
// carry from the group below; an approximated group (rcon_i bit set) instead
// predicts its carry-in from the WINDOW bits just below its boundary,
// assuming no carry enters that window. Group 0 approximated ignores cin_i.
module rapcla_accuracy_ctrl_adder #(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4,
  localparam int NGROUPS  = SIZE / GROUPSIZE
) (
  input  logic [SIZE-1:0]    a_i,
  input  logic [SIZE-1:0]    b_i,
  input  logic               cin_i,
  input  logic [NGROUPS-1:0] rcon_i,
  output logic [SIZE-1:0]    sum_o,
  output logic               cout_o
);

  // Carry leaving each group's ripple chain; index 0 is the adder carry-in.
  logic [NGROUPS:0] c_grp;

  assign c_grp[0] = cin_i;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    logic                 pred;
    logic [GROUPSIZE:0]   c;

    if (g == 0) begin : g_first
      assign pred = 1'b0;
    end else begin : g_win
      logic [WINDOW:0] w;
      assign w[0] = 1'b0;
      for (genvar k = 0; k < WINDOW; k++) begin : g_k
        localparam int IDX = g * GROUPSIZE - WINDOW + k;
        assign w[k+1] = (a_i[IDX] & b_i[IDX]) | (w[k] & (a_i[IDX] ^ b_i[IDX]));
      end
      assign pred = w[WINDOW];
    end

    assign c[0] = rcon_i[g] ? pred : c_grp[g];

    for (genvar k = 0; k < GROUPSIZE; k++) begin : g_bit
      localparam int BIT = g * GROUPSIZE + k;
      assign sum_o[BIT] = a_i[BIT] ^ b_i[BIT] ^ c[k];
      assign c[k+1]     = (a_i[BIT] & b_i[BIT]) | (c[k] & (a_i[BIT] ^ b_i[BIT]));
    end

    assign c_grp[g+1] = c[GROUPSIZE];
  end

  assign cout_o = c_grp[NGROUPS];

endmodule

// File: rtl/rapcla_accuracy_ctrl.sv
// Accuracy controller around one RAPCLA adder: accepts add requests, runs them
// exact / fixed-approximate / adaptive, and in adaptive mode re-checks every
// SAMPLE-th op exactly and tunes the approximation level once per epoch.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both high. Response outputs stay stable
// while rsp_valid_o is high and rsp_ready_i is low.
module rapcla_accuracy_ctrl
  import rapcla_accuracy_ctrl_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4,
  parameter int SAMPLE    = 4,
  parameter int EPOCH     = 8,
  parameter int ERR_MAX   = 2,
  localparam int NGROUPS  = groups_of(SIZE, GROUPSIZE),
  localparam int LW       = level_width(NGROUPS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [SIZE-1:0]    a_i,
  input  logic [SIZE-1:0]    b_i,
  input  logic               cin_i,
  input  logic [1:0]         qmode_i,
  input  logic [NGROUPS-1:0] cfg_mask_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [SIZE-1:0]    sum_o,
  output logic               cout_o,
  output logic [NGROUPS-1:0] approx_used_o,
  output logic [LW-1:0]      level_o,
  output logic [1:0]         dbg_state_o
);

  localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam int CW = $clog2(EPOCH + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE - 1);

  state_e             state_q;
  qmode_e             mode_q;
  logic [SIZE-1:0]    a_q, b_q, sum_q;
  logic               cin_q, cout_q;
  logic [NGROUPS-1:0] mask_q, used_q;
  logic [LW-1:0]      level_q, level_d;
  logic [SW-1:0]      samp_q;
  logic [CW-1:0]      chk_q, chk_d, err_q, err_d;

  logic [NGROUPS-1:0] rcon, lvl_mask;
  logic [SIZE-1:0]    add_sum;
  logic               add_cout, mismatch, epoch_end;

  assign lvl_mask = NGROUPS'(level_mask(32'(level_q)));

  // Select the adder configuration: exact during the re-check, else by mode.
  always_comb begin
    rcon = '0;
    if (state_q != ST_CHECK) begin
      case (mode_q)
        QM_FIXED: rcon = mask_q;
        QM_ADAPT: rcon = lvl_mask;
        default:  rcon = '0;
      endcase
    end
  end

  rapcla_accuracy_ctrl_adder #(
    .SIZE      (SIZE),
    .GROUPSIZE (GROUPSIZE),
    .WINDOW    (WINDOW)
  ) u_rapcla_p_v (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .rcon_i (rcon),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Error/epoch bookkeeping for a CHECK cycle, including the level decision.
  always_comb begin
    mismatch = {add_cout, add_sum} != {cout_q, sum_q};
    err_d    = err_q;
    if (mismatch && (err_q != CW'(EPOCH))) err_d = err_q + CW'(1);
    chk_d     = chk_q + CW'(1);
    epoch_end = (chk_d == CW'(EPOCH));
    level_d   = level_q;
    if (epoch_end) begin
      if (err_d > CW'(ERR_MAX)) begin
        if (level_q != '0) level_d = level_q - LW'(1);
      end else if (err_d == '0) begin
        if (level_q != LW'(NGROUPS)) level_d = level_q + LW'(1);
      end
    end
  end

  // Controller FSM with operand capture, result latching and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= QM_EXACT;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      mask_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      used_q  <= '0;
      level_q <= '0;
      samp_q  <= '0;
      chk_q   <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            cin_q   <= cin_i;
            mask_q  <= cfg_mask_i;
            mode_q  <= (qmode_i == QM_RSVD) ? QM_EXACT : qmode_e'(qmode_i);
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          sum_q  <= add_sum;
          cout_q <= add_cout;
          used_q <= rcon;
          if (mode_q == QM_ADAPT) begin
            samp_q  <= (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
            state_q <= (samp_q == SAMP_LAST) ? ST_CHECK : ST_RESP;
          end else begin
            state_q <= ST_RESP;
          end
        end
        ST_CHECK: begin
          sum_q   <= add_sum;
          cout_q  <= add_cout;
          used_q  <= '0;
          err_q   <= epoch_end ? '0 : err_d;
          chk_q   <= epoch_end ? '0 : chk_d;
          level_q <= level_d;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign sum_o         = sum_q;
  assign cout_o        = cout_q;
  assign approx_used_o = used_q;
  assign level_o       = level_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rapcla_accuracy_ctrl.sv
// Bench for rapcla_accuracy_ctrl: directed vectors, random fixed/exact ops and
// adaptive epochs against an arithmetic group-wise adder model and a
// per-operation accuracy-control model.
module tb_rapcla_accuracy_ctrl;
  import rapcla_accuracy_ctrl_pkg::*;

  localparam int SIZE      = 16;
  localparam int GROUPSIZE = 8;
  localparam int WINDOW    = 4;
  localparam int SAMPLE    = 4;
  localparam int EPOCH     = 8;
  localparam int ERR_MAX   = 2;
  localparam int NG        = SIZE / GROUPSIZE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0, req_ready;
  logic [15:0]     a = '0, b = '0;
  logic            cin = 1'b0;
  logic [1:0]      qmode = '0, cfg_mask = '0;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [15:0]     sum;
  logic            cout;
  logic [1:0]      approx_used, level, dbg_state;

  rapcla_accuracy_ctrl #(
    .SIZE(SIZE), .GROUPSIZE(GROUPSIZE), .WINDOW(WINDOW),
    .SAMPLE(SAMPLE), .EPOCH(EPOCH), .ERR_MAX(ERR_MAX)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .a_i           (a),
    .b_i           (b),
    .cin_i         (cin),
    .qmode_i       (qmode),
    .cfg_mask_i    (cfg_mask),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .sum_o         (sum),
    .cout_o        (cout),
    .approx_used_o (approx_used),
    .level_o       (level),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] exp_q[$];   // {approx_used, cout, sum}

  // Accuracy-control model: op counts, epoch tallies, level.
  int m_level = 0;
  int m_adapt = 0;
  int m_chk   = 0;
  int m_err   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Group-wise adder model with plain integer arithmetic.
  function automatic logic [16:0] model_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic [1:0] rcon);
    int carry, res, xg, yg, cg, wx, wy, s;
    carry = int'(ci);
    res   = 0;
    for (int g = 0; g < NG; g++) begin
      xg = (int'(x) >> (g * GROUPSIZE)) & ((1 << GROUPSIZE) - 1);
      yg = (int'(y) >> (g * GROUPSIZE)) & ((1 << GROUPSIZE) - 1);
      if (((int'(rcon) >> g) & 1) == 1) begin
        if (g == 0) begin
          cg = 0;
        end else begin
          wx = (int'(x) >> (g * GROUPSIZE - WINDOW)) & ((1 << WINDOW) - 1);
          wy = (int'(y) >> (g * GROUPSIZE - WINDOW)) & ((1 << WINDOW) - 1);
          cg = (wx + wy) >> WINDOW;
        end
      end else begin
        cg = carry;
      end
      s     = xg + yg + cg;
      res   = res | ((s & ((1 << GROUPSIZE) - 1)) << (g * GROUPSIZE));
      carry = s >> GROUPSIZE;
    end
    return 17'((carry << SIZE) | res);
  endfunction

  function automatic logic [1:0] lvl_rcon(input int lvl);
    return 2'((1 << lvl) - 1);
  endfunction

  // Random operands whose approximate result at the given level is exact
  // (want_err=0) or wrong (want_err=1).
  task automatic gen_ops(input int lvl, input bit want_err,
                         output logic [15:0] x, output logic [15:0] y, output logic ci);
    bit differs;
    for (int t = 0; t < 2000; t++) begin
      x  = 16'($urandom_range(0, 65535));
      y  = 16'($urandom_range(0, 65535));
      ci = 1'($urandom_range(0, 1));
      differs = model_add(x, y, ci, lvl_rcon(lvl)) != model_add(x, y, ci, 2'b00);
      if (differs == want_err) break;
    end
  endtask

  // ---------------- driver: one full request/response ----------------
  task automatic do_op(input logic [1:0] mode, input logic [1:0] mask,
                       input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input int stall);
    logic [1:0]  eff, rcon;
    logic [16:0] ex, ap;
    logic [18:0] got;
    bit          chk;
    int          lat_exp, n;

    eff  = (mode == 2'd3) ? 2'd0 : mode;
    rcon = (eff == 2'd0) ? 2'b00 : (eff == 2'd1) ? mask : lvl_rcon(m_level);
    ex   = model_add(x, y, ci, 2'b00);
    ap   = model_add(x, y, ci, rcon);
    chk  = 1'b0;
    if (eff == 2'd2) begin
      chk = (m_adapt % SAMPLE) == (SAMPLE - 1);
      m_adapt++;
    end
    if (chk) begin
      if ((ap != ex) && (m_err < EPOCH)) m_err++;
      m_chk++;
      if (m_chk == EPOCH) begin
        if (m_err > ERR_MAX) begin
          if (m_level > 0) m_level--;
        end else if (m_err == 0) begin
          if (m_level < NG) m_level++;
        end
        m_chk = 0;
        m_err = 0;
      end
      exp_q.push_back({2'b00, ex});
      lat_exp = 3;
    end else begin
      exp_q.push_back({rcon, ap});
      lat_exp = 2;
    end

    @(negedge clk);
    req_valid = 1'b1;
    a = x; b = y; cin = ci; qmode = mode; cfg_mask = mask;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("accept", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", 32'(n), 32'(lat_exp));
    got = {approx_used, cout, sum};
    check_val("result", 32'(got), 32'(exp_q.pop_front()));
    check_val("level", 32'(level), 32'(m_level));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val("stall_hold", 32'({rsp_valid, req_ready, approx_used, cout, sum}),
                32'({1'b1, 1'b0, got}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] x, y;
    logic        ci;
    int          n;

    // Reset values.
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_outputs", 32'({rsp_valid, approx_used, cout, sum, level}), 32'd0);
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed vectors.
    do_op(2'd0, 2'b00, 16'h01E8, 16'h011F, 1'b1, 0);
    do_op(2'd0, 2'b00, 16'hF1E0, 16'hF000, 1'b1, 5);
    do_op(2'd1, 2'b11, 16'h01E8, 16'h011F, 1'b1, 0);
    do_op(2'd3, 2'b11, 16'h01E8, 16'h011F, 1'b1, 1);

    // Random exact/fixed/reserved ops: adaptive bookkeeping untouched.
    for (int i = 0; i < 20; i++) begin
      do_op(2'($urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2));
    end

    // Two error-free epochs raise the level to 2, a third shows saturation.
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < SAMPLE * EPOCH; i++) begin
        gen_ops(m_level, 1'b0, x, y, ci);
        do_op(2'd2, 2'($urandom_range(0, 3)), x, y, ci, $urandom_range(0, 1));
      end
      check_val("epoch_level", 32'(level), 32'((e + 1 > NG) ? NG : e + 1));
    end

    // One epoch where every op is wrong at level 2: level drops to 1.
    for (int i = 0; i < SAMPLE * EPOCH; i++) begin
      gen_ops(m_level, 1'b1, x, y, ci);
      do_op(2'd2, 2'b00, x, y, ci, 0);
    end
    check_val("err_epoch_level", 32'(level), 32'd1);

    // Advance to the op that will be checked, then reset during its CHECK.
    while ((m_adapt % SAMPLE) != (SAMPLE - 1)) begin
      gen_ops(m_level, 1'b0, x, y, ci);
      do_op(2'd2, 2'b00, x, y, ci, 0);
    end
    @(negedge clk);
    req_valid = 1'b1;
    qmode = 2'd2;
    a = 16'h1234; b = 16'h4321; cin = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("in_check", 32'(dbg_state), 32'(ST_CHECK));
    rst = 1'b1;
    #1;
    check_val("midrst_outputs", 32'({rsp_valid, req_ready, approx_used, cout, sum, level}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_level = 0; m_adapt = 0; m_chk = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end

    // Behaves as first after reset: ops 1-3 unchecked, op 4 checked.
    for (int i = 0; i < SAMPLE; i++) begin
      do_op(2'd2, 2'b00, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rapcla_accuracy_ctrl.md
# rapcla_accuracy_ctrl

Request/response controller that sequences the reconfigurable approximate carry look-ahead adder and owns its per-group approximation configuration (ApproxRCON). It accepts add requests over a valid/ready handshake and runs each operation on the adder in exact, fixed-approximate or adaptive mode. In adaptive mode it periodically re-executes an operation exactly, counts mismatches per epoch, and moves the approximation level up or down. It sits between the operand source and the result consumer, wrapping a single adder instance.

## Interface
- SIZE, 16, operand width
- GROUPSIZE, 8, adder group width; NGROUPS = SIZE/GROUPSIZE, derived
- WINDOW, 4, adder carry-prediction window, passed through to the adder
- SAMPLE, 4, adaptive mode: every SAMPLE-th accepted op is checked
- EPOCH, 8, checked ops per adaptation epoch
- ERR_MAX, 2, mismatch count per epoch above which the level drops
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  controller can accept a request
- A, B  in  SIZE  operands
- CIN  in  1  carry in
- QMODE  in  2  0 exact, 1 fixed (CFG_MASK), 2 adaptive, 3 treated as 0
- CFG_MASK  in  NGROUPS  ApproxRCON used in fixed mode; bit i=1 approximates group i
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  consumer accepts response
- SUM  out  SIZE  result
- COUT  out  1  result carry out
- APPROX_USED  out  NGROUPS  ApproxRCON that produced SUM (0 if result is exact)
- LEVEL  out  clog2(NGROUPS+1)  current adaptive level

## Operation
- States: IDLE, EXEC, CHECK, RESP.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY, register A, B, CIN, QMODE, CFG_MASK; go EXEC.
- EXEC: adder driven from registered operands with RCON = 0 (exact), CFG_MASK (fixed), or LVLMASK (adaptive; low LEVEL bits set). Result latched into SUM/COUT/APPROX_USED. If adaptive and sample counter == SAMPLE-1, go CHECK; else RESP.
- CHECK: same operands, RCON=0. Compare {COUT,SUM} exact vs. latched; mismatch increments error counter (saturating at EPOCH). SUM/COUT replaced by exact result, APPROX_USED=0. Increment checked-op counter; go RESP.
- RESP: RSP_VALID=1, outputs held stable until RSP_READY; then go IDLE.
- Sample counter: advances modulo SAMPLE only on adaptive accepts; untouched by modes 0/1/3.
- Epoch end (checked-op counter reaches EPOCH, evaluated in CHECK): err > ERR_MAX -> LEVEL-1 (saturate 0); err == 0 -> LEVEL+1 (saturate NGROUPS); else hold. Counters clear. New LEVEL applies from next accepted op.
- Mode changes between requests do not reset LEVEL or counters.

## Timing
- Reset values: REQ_READY=0 during RST, 1 first cycle after; RSP_VALID=0, SUM=0, COUT=0, APPROX_USED=0, LEVEL=0, all counters 0, state IDLE.
- Latency accept -> RSP_VALID: 2 cycles unchecked, 3 cycles checked.
- Max throughput: one op per 3 cycles (unchecked, RSP_READY held high).
- REQ_READY low in EXEC, CHECK, RESP; no request buffering.
- RSP_READY low in RESP: stall indefinitely, outputs unchanged.
- RST asserted mid-operation: immediate return to reset values; in-flight op dropped, no response.
- Adder is combinational; its inputs come only from registers, outputs sampled at end of EXEC/CHECK.

## Structure
- Shared package: QMODE encodings, state encoding, NGROUPS/level-width derivation, helper function level -> mask.
- One sub-module: the existing RAPCLA_p_v adder instance, parameterised SIZE/GROUPSIZE/WINDOW. Controller FSM and counters stay in this module.

## Test plan
- QMODE=0, A=0x01E8, B=0x011F, CIN=1 -> RSP_VALID 2 cycles after accept, SUM=0x0308, COUT=0, APPROX_USED=00.
- QMODE=0, A=0xF1E0, B=0xF000, CIN=1 -> SUM=0xE1E1, COUT=1; hold RSP_READY=0 for 5 cycles -> outputs stable, REQ_READY=0.
- QMODE=1, CFG_MASK=11, A=0x01E8, B=0x011F, CIN=1 -> SUM/COUT equal adder model with RCON=11, APPROX_USED=11.
- QMODE=2 from reset, 32 error-free ops (EPOCH checked) -> LEVEL 0->1; next 32 error-free ops -> LEVEL 2, saturates; every 4th op takes 3 cycles with APPROX_USED=00.
- QMODE=2 at LEVEL=2, 32 ops chosen so every checked op mismatches in the model -> err=8 > 2, LEVEL drops to 1 at epoch end.
- RST pulse during CHECK -> RSP_VALID=0, LEVEL=0, counters cleared; next request behaves as first after reset.
